// File: rtl/aux_arb.sv
// Two-port round-robin arbiter for the AUX byte-transaction port (ARM window A, link sequencer B).
// Define AUX_RETRY_EN to retry auxerr completions up to RETRIES times before reporting the error.
//
// state | meaning
// IDLE  | waiting for a_req/b_req; grant and latch the transaction
// BUSY  | auxreq held; waiting for auxack or timeout
// DONE  | port ack pulse; one cycle with no grant so the requester can drop req
// GAP   | (AUX_RETRY_EN only) one cycle with auxreq low before re-issuing
module aux_arb #(
  parameter int TIMEOUT = 4096,
  parameter int RETRIES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [19:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [19:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [7:0]  b_rdata,
  output logic        auxreq,
  output logic        auxwr,
  output logic [19:0] auxaddr,
  output logic [7:0]  auxwdata,
  input  logic        auxack,
  input  logic        auxerr,
  input  logic [7:0]  auxrdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

`ifdef AUX_RETRY_EN
  localparam int RW = (RETRIES > 1) ? $clog2(RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} state_t;
  logic [RW-1:0] retry_cnt;
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

  state_t        state;
  logic          gnt_b;
  logic [CW-1:0] cnt;
  logic          pick_b;

  // On a tie B wins only if A was granted last; gnt_b doubles as the last-grant pointer.
  assign pick_b = b_req & (~a_req | ~gnt_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_b    <= 1'b1;
      cnt      <= '0;
      auxreq   <= 1'b0;
      auxwr    <= 1'b0;
      auxaddr  <= '0;
      auxwdata <= '0;
      a_ack    <= 1'b0;
      a_err    <= 1'b0;
      a_rdata  <= '0;
      b_ack    <= 1'b0;
      b_err    <= 1'b0;
      b_rdata  <= '0;
`ifdef AUX_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            gnt_b    <= pick_b;
            auxwr    <= pick_b ? b_wr    : a_wr;
            auxaddr  <= pick_b ? b_addr  : a_addr;
            auxwdata <= pick_b ? b_wdata : a_wdata;
            auxreq   <= 1'b1;
            cnt      <= '0;
`ifdef AUX_RETRY_EN
            retry_cnt <= '0;
`endif
            state    <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (auxack) begin
`ifdef AUX_RETRY_EN
            if (auxerr && (retry_cnt < RETRY_MAX)) begin
              retry_cnt <= retry_cnt + 1'b1;
              auxreq    <= 1'b0;
              cnt       <= '0;
              state     <= GAP;
            end else
`endif
            begin
              auxreq <= 1'b0;
              state  <= DONE;
              if (gnt_b) begin
                b_ack   <= 1'b1;
                b_err   <= auxerr;
                b_rdata <= auxrdata;
              end else begin
                a_ack   <= 1'b1;
                a_err   <= auxerr;
                a_rdata <= auxrdata;
              end
            end
          end else if (cnt == TO_LAST) begin
            // Timeout: fail the transaction but keep the previous read byte.
            auxreq <= 1'b0;
            state  <= DONE;
            if (gnt_b) begin
              b_ack <= 1'b1;
              b_err <= 1'b1;
            end else begin
              a_ack <= 1'b1;
              a_err <= 1'b1;
            end
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
`ifdef AUX_RETRY_EN
        GAP: begin
          auxreq <= 1'b1;
          state  <= BUSY;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aux_arb.sv
// Directed bench for aux_arb: vector table for single transactions plus hand sequences
// for tie-break, round-robin, timeout, retry and mid-transaction reset.
module tb_aux_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_wr, a_ack, a_err;
  logic [19:0] a_addr;
  logic [7:0]  a_wdata, a_rdata;
  logic        b_req, b_wr, b_ack, b_err;
  logic [19:0] b_addr;
  logic [7:0]  b_wdata, b_rdata;
  logic        auxreq, auxwr, auxack, auxerr;
  logic [19:0] auxaddr;
  logic [7:0]  auxwdata, auxrdata;

  int checks = 0;
  int errors = 0;

  aux_arb #(.TIMEOUT(16), .RETRIES(3)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .auxreq(auxreq), .auxwr(auxwr), .auxaddr(auxaddr), .auxwdata(auxwdata),
    .auxack(auxack), .auxerr(auxerr), .auxrdata(auxrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port_b;
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  wdata;
    int          k;       // BUSY cycle (1-based) in which auxack is driven
    logic [7:0]  rd;
    logic        exp_err;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] exp_a_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_auxreq(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!auxreq && n < limit);
    if (!auxreq) chk("auxreq_wait_expired", 32'(auxreq), 32'd1);
  endtask

  // Called at a BUSY negedge; returns at the negedge of the following cycle.
  task automatic ack_now(input logic err, input logic [7:0] rd);
    auxack = 1'b1;
    auxerr = err;
    auxrdata = rd;
    tick();
    auxack = 1'b0;
    auxerr = 1'b0;
    auxrdata = 8'h5E;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    auxack = 0; auxerr = 0; auxrdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    vecs[0] = '{1'b0, 1'b0, 20'h00100, 8'h00, 4,  8'h12, 1'b0, 8'h12};
    vecs[1] = '{1'b1, 1'b1, 20'hABCDE, 8'h5A, 1,  8'h00, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 20'hFFFFF, 8'hFF, 2,  8'h77, 1'b0, 8'h77};
    vecs[3] = '{1'b1, 1'b0, 20'h00000, 8'h3C, 5,  8'hC3, 1'b0, 8'hC3};
    vecs[4] = '{1'b0, 1'b0, 20'h12345, 8'h00, 16, 8'h3C, 1'b0, 8'h3C};

    do_reset();
    chk("rst_auxreq", 32'(auxreq), 0);
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_b_ack", 32'(b_ack), 0);
    chk("rst_a_err", 32'(a_err), 0);
    chk("rst_b_err", 32'(b_err), 0);
    chk("rst_auxaddr", 32'(auxaddr), 0);
    chk("rst_auxwdata", 32'(auxwdata), 0);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    chk("rst_b_rdata", 32'(b_rdata), 0);

    // Tie after reset: A first, then B right after DONE.
    tick();
    a_req = 1; a_addr = 20'h0A0A1; b_req = 1; b_addr = 20'h0B0B1;
    wait_auxreq(10, n);
    chk("tie_latency", 32'(n), 2);
    chk("tie_first_addr", 32'(auxaddr), 32'h0A0A1);
    ack_now(1'b0, 8'h21);
    chk("tie_a_ack", 32'(a_ack), 1);
    chk("tie_b_ack_low", 32'(b_ack), 0);
    a_req = 0;
    @(negedge clk);
    chk("tie_idle_auxreq", 32'(auxreq), 0);
    @(negedge clk);
    chk("tie_b_auxreq", 32'(auxreq), 1);
    chk("tie_b_addr", 32'(auxaddr), 32'h0B0B1);
    ack_now(1'b0, 8'h22);
    chk("tie_b_ack", 32'(b_ack), 1);
    chk("tie_b_rdata", 32'(b_rdata), 32'h22);
    b_req = 0;
    @(negedge clk);

    // Both held continuously: grants alternate A,B,A,B.
    a_req = 1; a_addr = 20'h0A0A2; b_req = 1; b_addr = 20'h0B0B2;
    for (int i = 0; i < 4; i++) begin
      logic exp_b;
      exp_b = (i % 2) == 1;
      wait_auxreq(10, n);
      chk("rr_addr", 32'(auxaddr), exp_b ? 32'h0B0B2 : 32'h0A0A2);
      ack_now(1'b0, 8'(i));
      chk("rr_a_ack", 32'(a_ack), exp_b ? 0 : 1);
      chk("rr_b_ack", 32'(b_ack), exp_b ? 1 : 0);
    end
    a_req = 0; b_req = 0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      tick();
      if (vecs[v].port_b) begin
        b_req = 1; b_wr = vecs[v].wr; b_addr = vecs[v].addr; b_wdata = vecs[v].wdata;
      end else begin
        a_req = 1; a_wr = vecs[v].wr; a_addr = vecs[v].addr; a_wdata = vecs[v].wdata;
      end
      wait_auxreq(10, n);
      chk("vec_latency", 32'(n), 2);
      chk("vec_auxaddr", 32'(auxaddr), 32'(vecs[v].addr));
      chk("vec_auxwr", 32'(auxwr), 32'(vecs[v].wr));
      chk("vec_auxwdata", 32'(auxwdata), 32'(vecs[v].wdata));
      repeat (vecs[v].k - 1) @(negedge clk);
      chk("vec_auxreq_held", 32'(auxreq), 1);
      ack_now(1'b0, vecs[v].rd);
      chk("vec_auxreq_drop", 32'(auxreq), 0);
      chk("vec_ack", 32'(vecs[v].port_b ? b_ack : a_ack), 1);
      chk("vec_other_ack", 32'(vecs[v].port_b ? a_ack : b_ack), 0);
      chk("vec_err", 32'(vecs[v].port_b ? b_err : a_err), 32'(vecs[v].exp_err));
      chk("vec_rdata", 32'(vecs[v].port_b ? b_rdata : a_rdata), 32'(vecs[v].exp_rd));
      if (!vecs[v].port_b) exp_a_rd = vecs[v].exp_rd;
      a_req = 0; b_req = 0;
      @(negedge clk);
      chk("vec_ack_pulse", 32'(vecs[v].port_b ? b_ack : a_ack), 0);
    end

    // Timeout with TIMEOUT=16, then late auxacks ignored.
    tick();
    a_req = 1; a_addr = 20'h0DEAD; a_wr = 0;
    wait_auxreq(10, n);
    pulses = 1;
    while (auxreq && pulses < 40) begin
      @(negedge clk);
      if (auxreq) pulses++;
    end
    chk("to_busy_cycles", 32'(pulses), 16);
    chk("to_a_ack", 32'(a_ack), 1);
    chk("to_a_err", 32'(a_err), 1);
    chk("to_a_rdata_kept", 32'(a_rdata), 32'(exp_a_rd));
    a_req = 0;
    auxack = 1; auxrdata = 8'hEE;
    repeat (2) @(posedge clk);
    #1 auxack = 0;
    repeat (3) begin
      @(negedge clk);
      chk("late_a_ack", 32'(a_ack), 0);
      chk("late_b_ack", 32'(b_ack), 0);
      chk("late_auxreq", 32'(auxreq), 0);
    end

    // Error completions, with and without retry.
    tick();
    b_req = 1; b_addr = 20'h0B0B3; b_wr = 1;
    wait_auxreq(10, n);
`ifdef AUX_RETRY_EN
    pulses = 1;
    for (int e = 0; e < 2; e++) begin
      ack_now(1'b1, 8'h44);
      chk("retry_no_ack", 32'(b_ack), 0);
      chk("retry_gap", 32'(auxreq), 0);
      @(negedge clk);
      chk("retry_reissue", 32'(auxreq), 1);
      chk("retry_addr", 32'(auxaddr), 32'h0B0B3);
      if (auxreq) pulses++;
    end
    ack_now(1'b0, 8'h99);
    chk("retry_pulses", 32'(pulses), 3);
    chk("retry_b_ack", 32'(b_ack), 1);
    chk("retry_b_err", 32'(b_err), 0);
    chk("retry_b_rdata", 32'(b_rdata), 32'h99);
    b_req = 0;
    @(negedge clk);
    tick();
    b_req = 1;
    wait_auxreq(10, n);
    for (int e = 0; e < 3; e++) begin
      ack_now(1'b1, 8'h44);
      chk("exh_no_ack", 32'(b_ack), 0);
      @(negedge clk);
    end
    ack_now(1'b1, 8'h55);
    chk("exh_b_ack", 32'(b_ack), 1);
    chk("exh_b_err", 32'(b_err), 1);
    chk("exh_b_rdata", 32'(b_rdata), 32'h55);
`else
    ack_now(1'b1, 8'h44);
    chk("err_b_ack", 32'(b_ack), 1);
    chk("err_b_err", 32'(b_err), 1);
    chk("err_b_rdata", 32'(b_rdata), 32'h44);
`endif
    b_req = 0;
    @(negedge clk);

    // Reset during BUSY abandons the transaction; held request is then serviced.
    tick();
    a_req = 1; a_addr = 20'h0A0A4;
    wait_auxreq(10, n);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mrst_auxreq", 32'(auxreq), 0);
    chk("mrst_a_ack", 32'(a_ack), 0);
    chk("mrst_a_rdata", 32'(a_rdata), 0);
    rst = 0;
    wait_auxreq(5, n);
    chk("mrst_latency", 32'(n), 1);
    chk("mrst_addr", 32'(auxaddr), 32'h0A0A4);
    ack_now(1'b0, 8'h5D);
    chk("mrst_a_ack_after", 32'(a_ack), 1);
    chk("mrst_a_rdata_after", 32'(a_rdata), 32'h5D);
    a_req = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
